// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-side responder:
// FSM states, byte masks and beat-count decode.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_D,
    RD_I,
    DONE
  } state_e;

  localparam logic [3:0] ByteMask = 4'h1;
  localparam logic [3:0] HalfMask = 4'h3;
  localparam logic [3:0] WordMask = 4'hF;

  typedef struct packed {
    logic we;
    logic re;
    logic fe;
  } pend_t;

  function automatic logic [2:0] beats(
    input logic [3:0] mask
  );
    case (mask)
      ByteMask: beats = 3'd1;
      HalfMask: beats = 3'd2;
      default:  beats = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_beat_seq.sv
// Beat counter and address generator shared by
// the store, load and fetch sequences.
module mem_beat_seq #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] base,
  input  logic [2:0]        n,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic [2:0]        idx,
  output logic [2:0]        nidx,
  output logic              last,
  output logic              drain
);

  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) cnt <= 3'd0;
    else     cnt <= nidx;
  end

  // addr looks one beat ahead so the caller can register it;
  // base belongs to the op of the next cycle, n to the current one
  assign nidx  = start ? 3'd0 : cnt + 3'd1;
  assign addr  = base + ADDR_W'(nidx);
  assign idx   = cnt;
  assign last  = (cnt == n - 3'd1);
  assign drain = (cnt == n);

endmodule

// File: rtl/mem_ctrl.sv
// Byte-beat responder serving core fetch, load and
// store ports from one single-port byte RAM.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              ram_ce_i,
  input  logic              ram_re_i,
  input  logic [3:0]        ram_rvalid_bit_i,
  input  logic [31:0]       ram_raddr_i,
  output logic [31:0]       ram_rdata_o,
  input  logic              ram_we_i,
  input  logic [3:0]        ram_wvalid_bit_i,
  input  logic [31:0]       ram_waddr_i,
  input  logic [31:0]       ram_wdata_i,
  output logic              req_if_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  input  logic [7:0]        mem_din_i
);

  state_e state, nxt;
  pend_t  pend_now, pend_q, pend;

  logic [2:0]        n_cur, idx, nidx;
  logic [ADDR_W-1:0] base_nxt, seq_addr;
  logic              last, drain;
  logic              start, busy_nxt;
  logic [31:0]       asm_q, asm_nxt;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] a_nxt;
  logic [7:0]        dout_nxt;
  logic              wr_nxt;
  logic              unused_hi;

  assign pend_now.we = ram_ce_i & ram_we_i;
  assign pend_now.re = ram_ce_i & ram_re_i;
  assign pend_now.fe = rom_ce_i;
  assign pend = (state == IDLE) ? pend_now : pend_q;

  assign unused_hi = ^{rom_addr_i[31:ADDR_W],
                       ram_raddr_i[31:ADDR_W],
                       ram_waddr_i[31:ADDR_W],
                       nidx[2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pend_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE) pend_q <= pend_now;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (pend.we)      nxt = WR;
        else if (pend.re) nxt = RD_D;
        else if (pend.fe) nxt = RD_I;
      end
      WR: begin
        if (last) begin
          if (pend.re)      nxt = RD_D;
          else if (pend.fe) nxt = RD_I;
          else              nxt = DONE;
        end
      end
      RD_D: begin
        if (drain) nxt = pend.fe ? RD_I : DONE;
      end
      RD_I: begin
        if (drain) nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign busy_nxt = nxt inside {WR, RD_D, RD_I};
  assign start    = busy_nxt && (nxt != state);

  always_comb begin
    case (state)
      WR:      n_cur = beats(ram_wvalid_bit_i);
      RD_D:    n_cur = beats(ram_rvalid_bit_i);
      default: n_cur = 3'd4;
    endcase
  end

  always_comb begin
    case (nxt)
      WR:      base_nxt = ram_waddr_i[ADDR_W-1:0];
      RD_D:    base_nxt = ram_raddr_i[ADDR_W-1:0];
      default: base_nxt = rom_addr_i[ADDR_W-1:0];
    endcase
  end

  mem_beat_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk   (clk),
    .rst   (rst),
    .base  (base_nxt),
    .n     (n_cur),
    .start (start),
    .addr  (seq_addr),
    .idx   (idx),
    .nidx  (nidx),
    .last  (last),
    .drain (drain)
  );

  always_comb begin
    if (rst)                req_if_o = 1'b0;
    else if (state == IDLE) req_if_o = |pend_now;
    else                    req_if_o = (state != DONE);
    a_nxt    = busy_nxt ? seq_addr : mem_a_o;
    wr_nxt   = (nxt == WR);
    dout_nxt = mem_dout_o;
    if (nxt == WR)
      dout_nxt = ram_wdata_i[{nidx[1:0], 3'b000} +: 8];
    // RAM data lags the address by one beat
    lane    = 2'(idx - 3'd1);
    asm_nxt = asm_q;
    if (idx != 3'd0)
      asm_nxt[{lane, 3'b000} +: 8] = mem_din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_a_o     <= '0;
      mem_dout_o  <= '0;
      mem_wr_o    <= 1'b0;
      asm_q       <= '0;
      rom_data_o  <= '0;
      ram_rdata_o <= '0;
    end else begin
      mem_a_o    <= a_nxt;
      mem_dout_o <= dout_nxt;
      mem_wr_o   <= wr_nxt;
      if (start)
        asm_q <= '0;
      else if (state == RD_D || state == RD_I)
        asm_q <= asm_nxt;
      if (drain && state == RD_D) ram_rdata_o <= asm_nxt;
      if (drain && state == RD_I) rom_data_o  <= asm_nxt;
    end
  end

endmodule
